// File: rtl/jk_flop_bank_pkg.sv
// Shared types and default parameters for the jk_flop_bank register primitive.
package jk_flop_bank_pkg;

    typedef enum logic [1:0] {
        JKFB_JK   = 2'b00,
        JKFB_D    = 2'b01,
        JKFB_T    = 2'b10,
        JKFB_HOLD = 2'b11
    } jkfb_mode_t;

    localparam int JKFB_WIDTH_DEF = 8;
    localparam int JKFB_CNT_W_DEF = 16;

endpackage

// File: rtl/jkfb_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module jkfb_popcount
    import jk_flop_bank_pkg::*;
#(
    parameter int WIDTH = JKFB_WIDTH_DEF,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [OUT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/jk_flop_bank.sv
// WIDTH-bit JK/D/T/hold register bank with parallel load and edge flags.
// Optional saturating transition counter enabled by JK_FLOP_BANK_TOGGLE_CNT_EN.
module jk_flop_bank
    import jk_flop_bank_pkg::*;
#(
    parameter int               WIDTH     = JKFB_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = JKFB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall
`ifdef JK_FLOP_BANK_TOGGLE_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_q_nx;
    jkfb_mode_t       w_mode;

    assign w_mode = jkfb_mode_t'(mode);

    // Load outranks everything; en=0 behaves exactly like HOLD.
    always_comb begin
        w_q_nx = r_q;
        if (load) begin
            w_q_nx = load_val;
        end else if (en) begin
            case (w_mode)
                JKFB_JK: w_q_nx = (j & ~r_q) | (~k & r_q);
                JKFB_D:  w_q_nx = j;
                JKFB_T:  w_q_nx = r_q ^ j;
                default: w_q_nx = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= RESET_VAL;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_q    <= w_q_nx;
            r_rise <= w_q_nx & ~r_q;
            r_fall <= ~w_q_nx & r_q;
        end
    end

    assign q      = r_q;
    assign q_rise = r_rise;
    assign q_fall = r_fall;

`ifdef JK_FLOP_BANK_TOGGLE_CNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);

    logic [PC_W-1:0]  w_pc;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] r_cnt;

    jkfb_popcount #(
        .WIDTH (WIDTH),
        .OUT_W (PC_W)
    ) u_popcount (
        .i_bits  (w_q_nx ^ r_q),
        .o_count (w_pc)
    );

    // One spare bit on the sum makes overflow visible for saturation.
    always_comb begin
        w_sum    = {1'b0, r_cnt} + (CNT_W + 1)'(w_pc);
        w_cnt_nx = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        if (cnt_clr) begin
            w_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
        end
    end

    assign toggle_cnt = r_cnt;
    assign cnt_sat    = &r_cnt;
`endif

endmodule

// File: tb/tb_jk_flop_bank.sv
// Directed plus randomized bench for jk_flop_bank against a behavioural model.
module tb_jk_flop_bank;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam int         CW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] q, q_rise, q_fall;
    logic       cnt_clr = 1'b0;
`ifdef JK_FLOP_BANK_TOGGLE_CNT_EN
    logic [CW-1:0] toggle_cnt;
    logic          cnt_sat;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q = RV;
    logic [7:0] m_rise = '0;
    logic [7:0] m_fall = '0;
    int         m_cnt = 0;

    jk_flop_bank #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_val   (load_val),
        .q          (q),
        .q_rise     (q_rise),
        .q_fall     (q_fall)
`ifdef JK_FLOP_BANK_TOGGLE_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .toggle_cnt (toggle_cnt),
        .cnt_sat    (cnt_sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each bit follows the mode rule table directly.
    function automatic logic [7:0] model_next(input logic ld, input logic [7:0] lv,
                                              input logic e, input logic [1:0] md,
                                              input logic [7:0] jj, input logic [7:0] kk,
                                              input logic [7:0] q0);
        logic [7:0] r;
        r = q0;
        if (ld) return lv;
        if (!e || md == 2'd3) return q0;
        for (int b = 0; b < 8; b++) begin
            case (md)
                2'd0: begin
                    if (jj[b] && kk[b])       r[b] = ~q0[b];
                    else if (jj[b])           r[b] = 1'b1;
                    else if (kk[b])           r[b] = 1'b0;
                    else                      r[b] = q0[b];
                end
                2'd1:    r[b] = jj[b];
                default: r[b] = q0[b] ^ jj[b];
            endcase
        end
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".rise"}, 32'(q_rise), 32'(m_rise));
        chk({tag, ".fall"}, 32'(q_fall), 32'(m_fall));
`ifdef JK_FLOP_BANK_TOGGLE_CNT_EN
        chk({tag, ".cnt"}, 32'(toggle_cnt), 32'(m_cnt));
        chk({tag, ".sat"}, 32'(cnt_sat), 32'(m_cnt == 15));
`endif
    endtask

    task automatic step(input string tag, input logic ld, input logic [7:0] lv,
                        input logic e, input logic [1:0] md, input logic [7:0] jj,
                        input logic [7:0] kk, input logic clr);
        logic [7:0] nx;
        load = ld; load_val = lv; en = e; mode = md; j = jj; k = kk; cnt_clr = clr;
        nx     = model_next(ld, lv, e, md, jj, kk, m_q);
        m_rise = nx & ~m_q;
        m_fall = ~nx & m_q;
        if (clr) m_cnt = 0;
        else     m_cnt = (m_cnt + $countones(nx ^ m_q) > 15) ? 15 : m_cnt + $countones(nx ^ m_q);
        m_q = nx;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_q = RV; m_rise = '0; m_fall = '0; m_cnt = 0;
    endtask

    initial begin
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("jk1", 0, 8'h00, 1, 2'd0, 8'hF0, 8'h0F, 0);
        chk("jk1.const_q", 32'(q), 32'h0F0);
        chk("jk1.const_rise", 32'(q_rise), 32'h50);
        chk("jk1.const_fall", 32'(q_fall), 32'h05);
        step("jk_tgl", 0, 8'h00, 1, 2'd0, 8'hFF, 8'hFF, 0);
        chk("jk_tgl.const_q", 32'(q), 32'h0F);
        step("d", 0, 8'h00, 1, 2'd1, 8'h3C, 8'hA7, 0);
        chk("d.const_q", 32'(q), 32'h3C);
        step("t1", 0, 8'h00, 1, 2'd2, 8'h01, 8'hFF, 0);
        chk("t1.const_q", 32'(q), 32'h3D);
        step("t2", 0, 8'h00, 1, 2'd2, 8'h01, 8'h00, 0);
        chk("t2.const_q", 32'(q), 32'h3C);
        step("t3", 0, 8'h00, 1, 2'd2, 8'h01, 8'h00, 0);
        chk("t3.const_q", 32'(q), 32'h3D);
        step("hold", 0, 8'h00, 1, 2'd3, 8'hFF, 8'hFF, 0);
        chk("hold.const_rise", 32'(q_rise), 32'h0);
        step("en0", 0, 8'h00, 0, 2'd2, 8'hFF, 8'h55, 0);
        chk("en0.const_q", 32'(q), 32'h3D);
        step("load", 1, 8'h81, 0, 2'd2, 8'hFF, 8'h00, 0);
        chk("load.const_q", 32'(q), 32'h81);
        step("load_same", 1, 8'h81, 1, 2'd2, 8'hFF, 8'h00, 0);

        // Asynchronous reset asserted between edges while a load is pending.
        load = 1'b1; load_val = 8'h42; en = 1'b1; mode = 2'd1; j = 8'h18;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 8'h00, 1, 2'd1, 8'h18, 8'h00, 0);

`ifdef JK_FLOP_BANK_TOGGLE_CNT_EN
        step("cnt_tgl1", 0, 8'h00, 1, 2'd2, 8'hFF, 8'h00, 1);
        step("cnt_tgl2", 0, 8'h00, 1, 2'd2, 8'hFF, 8'h00, 0);
        step("cnt_tgl3", 0, 8'h00, 1, 2'd2, 8'hFF, 8'h00, 0);
        chk("cnt.const_sat_val", 32'(toggle_cnt), 32'd15);
        chk("cnt.const_sat_flag", 32'(cnt_sat), 32'd1);
        step("cnt_stay", 0, 8'h00, 1, 2'd2, 8'hFF, 8'h00, 0);
        chk("cnt.const_stay", 32'(toggle_cnt), 32'd15);
        step("cnt_clr", 0, 8'h00, 1, 2'd2, 8'hFF, 8'h00, 1);
        chk("cnt.const_clr", 32'(toggle_cnt), 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom),
                 2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
